tt_um_mult_seq: RTL and testbench
=================================

# tt_um_mult_seq

Parametrised sequential shift-add multiplier for a TinyTapeout tile, the next generation of the team's 2-bit combinational multiplier. It accepts two WIDTH-bit operands on the dedicated inputs and computes unsigned or two's-complement products over WIDTH cycles. An optional accumulate mode adds each new product to the previous result. A start/busy/done handshake runs on the bidirectional pins, and the product is held on the dedicated outputs until the next completion.

## Interface
- WIDTH, 4: operand width, legal range 2..4; the product is 2*WIDTH bits.
- clk  input  1  tile clock; all state is updated on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- ena  input  1  clock enable; when low, all registers hold.
- ui_in  input  8  operand A on [WIDTH-1:0], operand B on [4+WIDTH-1:4]; all other bits are ignored.
- uo_out  output  8  result register; bits [2*WIDTH-1:0] hold the product; upper bits are zero-extended in unsigned mode and sign-extended in signed mode.
- uio_in  input  8  [0] start, [1] signed mode, [2] accumulate; [7:3] are ignored.
- uio_out  output  8  [3] busy, [4] done; all other bits are 0.
- uio_oe  output  8  constant 8'b0001_1000.

## Operation
- One clock domain. Reset is asynchronous, active-low: clk and rst_n.
- FSM states:
  - IDLE: waits for a start rising edge; busy=0.
  - RUN: iteration counter counts 0..WIDTH-1; busy=1.
  - DONE: lasts exactly one cycle; done=1, busy=0. Next state is always IDLE.
- Start detection:
  - A start_q register samples uio_in[0] every enabled cycle, in every state.
  - A start edge is uio_in[0]=1 while start_q=0.
  - Edges are acted on only in IDLE. An edge arriving in RUN or DONE is discarded and is not queued.
- Capture on the accepted edge: A, B, signed and accumulate are latched. Changes on ui_in/uio_in after capture have no effect on the operation in progress.
- Signed mode:
  - Operands are converted to magnitudes and the magnitudes are multiplied unsigned.
  - The product is negated at completion if the operand signs differ.
  - Results are exact, e.g. (-2^(W-1))*(-2^(W-1)) = 2^(2W-2), which fits.
- Each RUN iteration: if multiplier bit i is 1, the shifted multiplicand is added into a 2*WIDTH-bit partial register; then i increments.
- Completion (RUN→DONE edge):
  - result = product, or, with accumulate set, result = old result + product mod 2^(2W).
  - Sign extension of uo_out uses the signed flag captured for this operation.
- uo_out changes only at completion or reset. It holds the last result through IDLE, RUN and DONE.
- ena low freezes the FSM, counter, start_q and result. There are no outputs toggling and no edge detection while ena is low.

## Timing
- Reset values: uo_out=0, busy=0, done=0, state=IDLE, start_q=0, result=0. uio_oe is constant and unaffected.
- Edge E0 samples the start edge: state becomes RUN and busy=1 in the following cycle.
- Edges E1..EW perform the WIDTH iterations. At edge EW the state becomes DONE, uo_out shows the new result, done=1 and busy=0.
- At E(W+1) the state returns to IDLE and done=0.
- Accept-to-done latency is WIDTH cycles. Throughput is one operation per WIDTH+2 cycles at minimum, because start must fall and rise again.
- Start held high continuously triggers exactly one operation.
- Start rising in the same cycle that DONE is entered is ignored.
- Reset asserted mid-RUN: all outputs clear immediately (asynchronously), the partial product is lost, and the accumulator clears to 0.
- ena deasserted mid-RUN stretches latency by the number of disabled cycles. The result is unchanged.

## Test plan
- Reset, then unsigned A=3, B=5 with a start pulse: busy is high for exactly 4 cycles; uo_out=0x0F with done=1 for 1 cycle; uo_out stays 0x0F afterwards.
- Unsigned A=15, B=15 → 0xE1. Signed A=-3 (0xD), B=5 → 0xF1. Signed A=-8, B=-8 → 0x40. Signed A=-8, B=7 → 0xC8.
- Accumulate: after the 0x0F result, accumulate with A=2, B=3 → 0x15. Then signed accumulate with A=-1, B=1 → 0x14. Wrap-around case: 0xE1 + 15*15 → 0xC2.
- Start held high for 20 cycles → exactly one done pulse. A second edge during RUN → no second operation.
- Reset asserted at iteration 2 of an operation → uo_out, busy and done are 0 immediately. A following op with A=2, B=2 → 0x04, with no stale accumulation.
- ena low for 3 cycles mid-RUN → done arrives 3 cycles later with the correct product. Repeat with WIDTH=2: A=3, B=3 unsigned → 0x09; signed A=-2, B=-2 → 0x04; latency 2 cycles.

Source files
------------

// File: rtl/tt_um_mult_seq_if.sv
// Tile pin bundle for the sequential multiplier: operands, handshake and result.
// The bench drives through master; the multiplier consumes through slave.
interface tt_um_mult_seq_if;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (output ui_in, output uio_in, input uo_out, input uio_out, input uio_oe);
    modport slave  (input ui_in, input uio_in, output uo_out, output uio_out, output uio_oe);
endinterface

// File: rtl/tt_um_mult_seq.sv
// Sequential shift-add multiplier (unsigned / sign-magnitude signed) with optional accumulate.
// One partial-product iteration per cycle; the result register only updates at completion.
module tt_um_mult_seq #(
    parameter int unsigned WIDTH = 4
) (
    input logic            clk,
    input logic            rst_n,
    input logic            ena,
    tt_um_mult_seq_if.slave io
);
    localparam int unsigned PW   = 2 * WIDTH;
    localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q;
    logic              start_q;
    logic              busy_q;
    logic              done_q;
    logic              sgn_q;
    logic              acc_q;
    logic              neg_q;
    logic [CntW-1:0]   cnt_q;
    logic [PW-1:0]     mcand_q;
    logic [WIDTH-1:0]  mplier_q;
    logic [PW-1:0]     partial_q;
    logic [7:0]        out_q;

    logic [WIDTH-1:0]  op_a, op_b, a_mag, b_mag;
    logic              sgn_in, a_neg, b_neg;
    logic [PW-1:0]     partial_nxt, prod, res_nxt;
    logic [7:0]        res_ext;
    logic              unused_bits;

    assign op_a   = io.ui_in[WIDTH-1:0];
    assign op_b   = io.ui_in[4+WIDTH-1:4];
    assign sgn_in = io.uio_in[1];
    assign a_neg  = sgn_in & op_a[WIDTH-1];
    assign b_neg  = sgn_in & op_b[WIDTH-1];
    // The magnitude of -2^(W-1) is 2^(W-1), which still fits in W unsigned bits.
    assign a_mag  = a_neg ? (~op_a + 1'b1) : op_a;
    assign b_mag  = b_neg ? (~op_b + 1'b1) : op_b;

    assign partial_nxt = partial_q + (mplier_q[0] ? mcand_q : '0);
    assign prod        = neg_q ? (~partial_nxt + 1'b1) : partial_nxt;
    assign res_nxt     = acc_q ? (out_q[PW-1:0] + prod) : prod;
    assign res_ext     = sgn_q ? 8'($signed(res_nxt)) : 8'(res_nxt);

    assign io.uo_out  = out_q;
    assign io.uio_out = {3'b000, done_q, busy_q, 3'b000};
    assign io.uio_oe  = 8'b0001_1000;

    assign unused_bits = ^{io.ui_in, io.uio_in[7:3]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            start_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sgn_q     <= 1'b0;
            acc_q     <= 1'b0;
            neg_q     <= 1'b0;
            cnt_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            partial_q <= '0;
            out_q     <= '0;
        end else if (ena) begin
            start_q <= io.uio_in[0];
            done_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (io.uio_in[0] && !start_q) begin
                        state_q   <= StRun;
                        busy_q    <= 1'b1;
                        sgn_q     <= sgn_in;
                        acc_q     <= io.uio_in[2];
                        neg_q     <= a_neg ^ b_neg;
                        cnt_q     <= '0;
                        mcand_q   <= {{WIDTH{1'b0}}, a_mag};
                        mplier_q  <= b_mag;
                        partial_q <= '0;
                    end
                end
                StRun: begin
                    partial_q <= partial_nxt;
                    mcand_q   <= mcand_q << 1;
                    mplier_q  <= mplier_q >> 1;
                    cnt_q     <= cnt_q + 1'b1;
                    // Last iteration folds straight into the result register.
                    if (cnt_q == CntW'(WIDTH - 1)) begin
                        state_q <= StDone;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        out_q   <= res_ext;
                    end
                end
                StDone: state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_tt_um_mult_seq.sv
// Directed bench for tt_um_mult_seq: WIDTH=4 and WIDTH=2 instances, hand-computed products.
module tb_tt_um_mult_seq;
    logic clk;
    logic rst_n;
    logic ena;
    int   n_vec;
    int   n_err;

    tt_um_mult_seq_if io4();
    tt_um_mult_seq_if io2();

    tt_um_mult_seq #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .ena(ena), .io(io4));
    tt_um_mult_seq #(.WIDTH(2)) dut2 (.clk(clk), .rst_n(rst_n), .ena(ena), .io(io2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] out_of(input bit w2);
        return w2 ? io2.uo_out : io4.uo_out;
    endfunction

    function automatic logic [7:0] uio_of(input bit w2);
        return w2 ? io2.uio_out : io4.uio_out;
    endfunction

    task automatic set_in(input bit w2, input logic [7:0] ui, input logic [7:0] uio);
        if (w2) begin
            io2.ui_in = ui;  io2.uio_in = uio;
        end else begin
            io4.ui_in = ui;  io4.uio_in = uio;
        end
    endtask

    // One full operation: raise start, wait (bounded) for done, check product/latency/hold.
    task automatic op(input bit w2, input logic [7:0] ui, input logic sgn, input logic acc,
                      input logic [7:0] exp_res, input int exp_lat, input string tag);
        int         lat;
        int         busy_n;
        logic [7:0] res;
        bit         found;
        lat = -1; busy_n = 0; res = 8'hxx; found = 0;
        @(negedge clk);
        set_in(w2, ui, {5'b0, acc, sgn, 1'b1});
        for (int c = 0; c < 40 && !found; c++) begin
            @(posedge clk); #1;
            if (uio_of(w2)[3]) busy_n++;
            if (uio_of(w2)[4]) begin
                found = 1; lat = c; res = out_of(w2);
            end
        end
        chk({tag, " result"}, {24'b0, res}, {24'b0, exp_res});
        chk({tag, " latency"}, lat, exp_lat);
        chk({tag, " busy cycles"}, busy_n, exp_lat);
        @(negedge clk);
        set_in(w2, 8'h00, 8'h00);
        @(posedge clk); #1;
        chk({tag, " done drop"}, {31'b0, uio_of(w2)[4]}, 32'd0);
        chk({tag, " held"}, {24'b0, out_of(w2)}, {24'b0, exp_res});
    endtask

    initial begin
        int dones;
        int done_at;
        n_vec = 0; n_err = 0;
        rst_n = 1'b0; ena = 1'b1;
        set_in(0, 8'h00, 8'h00);
        set_in(1, 8'h00, 8'h00);
        #12;
        chk("reset uo_out", {24'b0, io4.uo_out}, 32'd0);
        chk("reset uio_out", {24'b0, io4.uio_out}, 32'd0);
        chk("uio_oe", {24'b0, io4.uio_oe}, 32'h18);
        @(negedge clk); rst_n = 1'b1;

        op(0, 8'h53, 0, 0, 8'h0F, 4, "u 3*5");
        op(0, 8'hFF, 0, 0, 8'hE1, 4, "u 15*15");
        op(0, 8'h5D, 1, 0, 8'hF1, 4, "s -3*5");
        op(0, 8'h88, 1, 0, 8'h40, 4, "s -8*-8");
        op(0, 8'h78, 1, 0, 8'hC8, 4, "s -8*7");

        op(0, 8'h53, 0, 0, 8'h0F, 4, "u 3*5 again");
        op(0, 8'h32, 0, 1, 8'h15, 4, "acc +2*3");
        op(0, 8'h1F, 1, 1, 8'h14, 4, "acc s -1*1");
        op(0, 8'hFF, 0, 0, 8'hE1, 4, "u 15*15 again");
        op(0, 8'hFF, 0, 1, 8'hC2, 4, "acc wrap");

        // Start held for 20 cycles: exactly one operation (1*2).
        dones = 0;
        for (int c = 0; c < 26; c++) begin
            @(negedge clk);
            set_in(0, 8'h21, (c < 20) ? 8'h01 : 8'h00);
            @(posedge clk); #1;
            if (io4.uio_out[4]) dones++;
        end
        chk("held start dones", dones, 1);
        chk("held start result", {24'b0, io4.uo_out}, 32'h02);

        // Second rising edge while in RUN is discarded (3*3).
        dones = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            set_in(0, 8'h33, (c == 0 || c == 2) ? 8'h01 : 8'h00);
            @(posedge clk); #1;
            if (io4.uio_out[4]) dones++;
        end
        chk("edge in RUN dones", dones, 1);
        chk("edge in RUN result", {24'b0, io4.uo_out}, 32'h09);

        // Asynchronous reset during iteration 2.
        @(negedge clk);
        set_in(0, 8'h35, 8'h01);
        repeat (3) @(posedge clk);
        #2;
        chk("pre-reset busy", {31'b0, io4.uio_out[3]}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid-run reset uo_out", {24'b0, io4.uo_out}, 32'd0);
        chk("mid-run reset uio_out", {24'b0, io4.uio_out}, 32'd0);
        @(negedge clk);
        set_in(0, 8'h00, 8'h00);
        rst_n = 1'b1;
        op(0, 8'h22, 0, 1, 8'h04, 4, "post-reset acc 2*2");

        // ena low for three cycles mid-RUN stretches latency by three.
        done_at = -1;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            set_in(0, 8'h53, (c < 10) ? 8'h01 : 8'h00);
            ena = !(c >= 2 && c <= 4);
            @(posedge clk); #1;
            if (io4.uio_out[4] && done_at < 0) done_at = c;
        end
        ena = 1'b1;
        chk("ena stall done time", done_at, 7);
        chk("ena stall result", {24'b0, io4.uo_out}, 32'h0F);

        op(1, 8'h33, 0, 0, 8'h09, 2, "w2 u 3*3");
        op(1, 8'h22, 1, 0, 8'h04, 2, "w2 s -2*-2");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
